// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the port-A arbiter of the true dual-port RAM.
// Latency and backpressure behaviour are defined by the modules that import this package.
package ram_arb_pkg;

    typedef enum logic {
        ARB_INIT = 1'b0,
        ARB_RUN  = 1'b1
    } arb_state_e;

    // Round-robin successor: the requester after the one just served gets first look.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
        return (ptr == num_req - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: one-hot grant to the first set req bit at or after ptr.
// Purely combinational, zero latency; no backpressure, the caller consumes the grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int unsigned idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any          = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/tdpram_port_arbiter.sv
// Shares RAM port A among NUM_REQ valid/ready requesters after an optional zero-fill sweep.
// Grant is same-cycle; read data returns 1 cycle after grant; losers simply see ready=0.
module tdpram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int DATA_DEPTH       = 256,
    parameter int DATA_WIDTH       = 32,
    parameter int BYTE_WRITE_WIDTH = 8,
    parameter int INIT_CLEAR       = 1,
    parameter int ADDR_WIDTH       = $clog2(DATA_DEPTH),
    parameter int NB               = DATA_WIDTH / BYTE_WRITE_WIDTH
) (
    input  logic                                clk_a,
    input  logic                                rsta_n,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic [NUM_REQ-1:0][NB-1:0]          req_we_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0]               rsp_rdata_o,
    output logic                                init_done_o,
    output logic                                ram_en_o,
    output logic [NB-1:0]                       ram_we_o,
    output logic [ADDR_WIDTH-1:0]               ram_addr_o,
    output logic [DATA_WIDTH-1:0]               ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]               ram_rdata_i
);

    localparam int                    IW          = $clog2(NUM_REQ);
    localparam arb_state_e            RESET_STATE = (INIT_CLEAR != 0) ? ARB_INIT : ARB_RUN;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DATA_DEPTH - 1);

    typedef struct packed {
        logic                  en;
        logic [NB-1:0]         we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } ram_cmd_t;

    arb_state_e            state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic [IW-1:0]         rr_ptr_q;
    logic [NUM_REQ-1:0]    rsp_vld_q;

    logic [NUM_REQ-1:0]    gnt;
    logic [IW-1:0]         gnt_idx;
    logic                  gnt_any;
    logic                  rd_gnt_vld;
    ram_cmd_t              ram_cmd;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req     (req_valid_i),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // Gated by rsta_n so the RAM port and grants stay quiet while reset is held.
    always_comb begin
        ram_cmd     = '0;
        req_ready_o = '0;
        rd_gnt_vld  = 1'b0;
        if (rsta_n) begin
            if (state_q == ARB_INIT) begin
                ram_cmd.en   = 1'b1;
                ram_cmd.we   = '1;
                ram_cmd.addr = clr_addr_q;
            end else if (gnt_any) begin
                req_ready_o   = gnt;
                ram_cmd.en    = 1'b1;
                ram_cmd.we    = req_we_i[gnt_idx];
                ram_cmd.addr  = req_addr_i[gnt_idx];
                ram_cmd.wdata = req_wdata_i[gnt_idx];
                rd_gnt_vld    = (req_we_i[gnt_idx] == '0);
            end
        end
    end

    always_ff @(posedge clk_a or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q    <= RESET_STATE;
            clr_addr_q <= '0;
            rr_ptr_q   <= '0;
            rsp_vld_q  <= '0;
        end else begin
            case (state_q)
                ARB_INIT: begin
                    rsp_vld_q <= '0;
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q    <= ARB_RUN;
                        clr_addr_q <= '0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                default: begin
                    if (gnt_any) begin
                        rr_ptr_q <= IW'(rr_next(32'(gnt_idx), NUM_REQ));
                    end
                    rsp_vld_q <= rd_gnt_vld ? gnt : '0;
                end
            endcase
        end
    end

    assign init_done_o = (state_q == ARB_RUN);
    assign rsp_valid_o = rsp_vld_q;
    // Shared read bus is masked so idle cycles never leak stale RAM output.
    assign rsp_rdata_o = (|rsp_vld_q) ? ram_rdata_i : '0;

    assign ram_en_o    = ram_cmd.en;
    assign ram_we_o    = ram_cmd.we;
    assign ram_addr_o  = ram_cmd.addr;
    assign ram_wdata_o = ram_cmd.wdata;

endmodule

// File: tb/tb_tdpram_port_arbiter.sv
// Directed bench for tdpram_port_arbiter: a behavioural port-A RAM behind the swept instance,
// plus a second instance built without the clear sweep.
module tb_tdpram_port_arbiter;

    logic clk_a = 1'b0;
    always #5 clk_a = ~clk_a;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance under sweep (INIT_CLEAR=1)
    logic              rsta_n;
    logic [3:0]        req_valid;
    logic [3:0]        req_ready;
    logic [3:0][3:0]   req_we;
    logic [3:0][7:0]   req_addr;
    logic [3:0][31:0]  req_wdata;
    logic [3:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              init_done;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [7:0]        ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    // Instance without sweep (INIT_CLEAR=0)
    logic              rst1_n;
    logic [3:0]        req1_valid;
    logic [3:0]        req1_ready;
    logic [3:0][3:0]   req1_we;
    logic [3:0][7:0]   req1_addr;
    logic [3:0][31:0]  req1_wdata;
    logic [3:0]        rsp1_valid;
    logic [31:0]       rsp1_rdata;
    logic              init1_done;
    logic              ram1_en;
    logic [3:0]        ram1_we;
    logic [7:0]        ram1_addr;
    logic [31:0]       ram1_wdata;
    logic [31:0]       ram1_rdata;

    tdpram_port_arbiter #(
        .NUM_REQ(4), .DATA_DEPTH(256), .DATA_WIDTH(32), .BYTE_WRITE_WIDTH(8), .INIT_CLEAR(1)
    ) dut (
        .clk_a(clk_a), .rsta_n(rsta_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .init_done_o(init_done),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    tdpram_port_arbiter #(
        .NUM_REQ(4), .DATA_DEPTH(256), .DATA_WIDTH(32), .BYTE_WRITE_WIDTH(8), .INIT_CLEAR(0)
    ) dut_noclr (
        .clk_a(clk_a), .rsta_n(rst1_n),
        .req_valid_i(req1_valid), .req_ready_o(req1_ready), .req_we_i(req1_we),
        .req_addr_i(req1_addr), .req_wdata_i(req1_wdata),
        .rsp_valid_o(rsp1_valid), .rsp_rdata_o(rsp1_rdata), .init_done_o(init1_done),
        .ram_en_o(ram1_en), .ram_we_o(ram1_we), .ram_addr_o(ram1_addr),
        .ram_wdata_o(ram1_wdata), .ram_rdata_i(ram1_rdata)
    );

    assign ram1_rdata = 32'h0;

    // Port-A RAM model: read-first, byte enables, one cycle read latency.
    logic [31:0] mem [256];
    always @(posedge clk_a) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_a);
        #1;
    endtask

    // Called just after a posedge with reset released; ends just after the first RUN posedge.
    task automatic sweep_check(input string tag);
        int good;
        int pulses;
        good   = 0;
        pulses = 0;
        for (int c = 0; c < 256; c++) begin
            @(negedge clk_a);
            if (ram_en && ram_we == 4'hF && ram_addr == 8'(c) && ram_wdata == 32'h0 &&
                !init_done && req_ready == 4'h0) good++;
            if (rsp_valid != 4'h0) pulses++;
            step();
        end
        check_val({tag, "_sweep_cycles"}, 64'(good), 64'd256);
        check_val({tag, "_sweep_rsp"}, 64'(pulses), 64'd0);
        @(negedge clk_a);
        check_val({tag, "_done_after"}, 64'(init_done), 64'd1);
        check_val({tag, "_en_after"}, 64'(ram_en), 64'd0);
    endtask

    logic [3:0] exp_g;
    logic [3:0] exp_r;

    initial begin
        rsta_n     = 1'b0;
        rst1_n     = 1'b0;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req1_valid = '0;
        req1_we    = '0;
        req1_addr  = '0;
        req1_wdata = '0;
        repeat (3) step();

        // Reset values, with requests present
        req_valid  = 4'hF;
        req1_valid = 4'hF;
        @(negedge clk_a);
        check_val("rst_ready", 64'(req_ready), 64'h0);
        check_val("rst_en", 64'(ram_en), 64'h0);
        check_val("rst_we", 64'(ram_we), 64'h0);
        check_val("rst_rsp", 64'(rsp_valid), 64'h0);
        check_val("rst_done", 64'(init_done), 64'h0);
        check_val("rst_noclr_done", 64'(init1_done), 64'h1);
        check_val("rst_noclr_en", 64'(ram1_en), 64'h0);
        req_valid  = '0;
        req1_valid = '0;

        // No-clear instance grants in its first cycle
        step();
        rst1_n       = 1'b1;
        req1_valid   = 4'b0010;
        req1_addr[1] = 8'h07;
        @(negedge clk_a);
        check_val("noclr_ready", 64'(req1_ready), 64'h2);
        check_val("noclr_en", 64'(ram1_en), 64'h1);
        check_val("noclr_addr", 64'(ram1_addr), 64'h07);
        step();
        req1_valid = '0;
        @(negedge clk_a);
        check_val("noclr_rsp", 64'(rsp1_valid), 64'h2);

        // Sweep after reset release
        step();
        rsta_n = 1'b1;
        sweep_check("s1");

        // Read of swept address
        step();
        req_valid   = 4'b0001;
        req_addr[0] = 8'h10;
        @(negedge clk_a);
        check_val("rd10_ready", 64'(req_ready), 64'h1);
        check_val("rd10_addr", 64'(ram_addr), 64'h10);
        step();
        req_valid = '0;
        @(negedge clk_a);
        check_val("rd10_rsp", 64'(rsp_valid), 64'h1);
        check_val("rd10_data", 64'(rsp_rdata), 64'h0);

        // Only req3 with rr_ptr=1
        step();
        req_valid   = 4'b1000;
        req_addr[3] = 8'h20;
        @(negedge clk_a);
        check_val("r3_ready", 64'(req_ready), 64'h8);
        step();
        req_valid = '0;
        @(negedge clk_a);
        check_val("r3_rsp", 64'(rsp_valid), 64'h8);
        step();
        @(negedge clk_a);
        check_val("idle1_en", 64'(ram_en), 64'h0);
        check_val("idle1_rsp", 64'(rsp_valid), 64'h0);
        step();
        @(negedge clk_a);
        check_val("idle2_en", 64'(ram_en), 64'h0);

        // All four reading continuously: rr_ptr must be back at 0
        step();
        req_valid = 4'hF;
        for (int r = 0; r < 4; r++) req_addr[r] = 8'(r);
        for (int k = 0; k < 8; k++) begin
            exp_g = 4'b0001 << (k % 4);
            exp_r = (k == 0) ? 4'b0000 : (4'b0001 << ((k + 3) % 4));
            @(negedge clk_a);
            check_val($sformatf("rr_gnt%0d", k), 64'(req_ready), 64'(exp_g));
            check_val($sformatf("rr_rsp%0d", k), 64'(rsp_valid), 64'(exp_r));
            step();
        end
        req_valid = '0;
        @(negedge clk_a);
        check_val("rr_rsp_last", 64'(rsp_valid), 64'h8);
        check_val("rr_ready_idle", 64'(req_ready), 64'h0);

        // Full write, partial write, then read from another requester
        step();
        req_valid    = 4'b0010;
        req_we[1]    = 4'b1111;
        req_addr[1]  = 8'h05;
        req_wdata[1] = 32'hDEADBEEF;
        @(negedge clk_a);
        check_val("wr1_ready", 64'(req_ready), 64'h2);
        check_val("wr1_we", 64'(ram_we), 64'hF);
        step();
        req_we[1]    = 4'b0001;
        req_wdata[1] = 32'h000000AA;
        @(negedge clk_a);
        check_val("wr2_ready", 64'(req_ready), 64'h2);
        check_val("wr2_rsp", 64'(rsp_valid), 64'h0);
        step();
        req_valid   = 4'b0100;
        req_we[1]   = 4'b0000;
        req_addr[2] = 8'h05;
        @(negedge clk_a);
        check_val("rd5_ready", 64'(req_ready), 64'h4);
        check_val("rd5_prev_rsp", 64'(rsp_valid), 64'h0);
        step();
        req_valid = '0;
        @(negedge clk_a);
        check_val("rd5_rsp", 64'(rsp_valid), 64'h4);
        check_val("rd5_data", 64'(rsp_rdata), 64'hDEADBEAA);
        step();
        @(negedge clk_a);
        check_val("mask_rdata", 64'(rsp_rdata), 64'h0);

        // Reset with a read in flight drops the response
        step();
        req_valid   = 4'b0001;
        req_addr[0] = 8'h05;
        @(negedge clk_a);
        check_val("fl_ready", 64'(req_ready), 64'h1);
        @(posedge clk_a);
        #1;
        rsta_n    = 1'b0;
        req_valid = '0;
        @(negedge clk_a);
        check_val("fl_rsp_dropped", 64'(rsp_valid), 64'h0);
        check_val("fl_done", 64'(init_done), 64'h0);
        check_val("fl_en", 64'(ram_en), 64'h0);

        // Reset mid-sweep at address 100
        step();
        rsta_n = 1'b1;
        repeat (100) step();
        @(negedge clk_a);
        check_val("mid_addr", 64'(ram_addr), 64'd100);
        #1;
        rsta_n = 1'b0;
        #1;
        check_val("mid_rst_en", 64'(ram_en), 64'h0);
        check_val("mid_rst_addr", 64'(ram_addr), 64'h0);
        step();
        rsta_n = 1'b1;
        sweep_check("s2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
